// File: rtl/muldiv_seq_if.sv
// rtl/muldiv_seq_if.sv - Execute-stage handshake between the pipeline and the multiply/divide sequencer
interface muldiv_seq_if #(
    parameter int XLEN = 32
);
    logic            startE;
    logic [2:0]      funct3E;
    logic [XLEN-1:0] SrcAE;
    logic [XLEN-1:0] SrcBE;
    logic            FlushE;
    logic            MDBusyE;
    logic            MDDoneE;
    logic [XLEN-1:0] MDResultE;

    modport master (
        output startE, funct3E, SrcAE, SrcBE, FlushE,
        input  MDBusyE, MDDoneE, MDResultE
    );

    modport slave (
        input  startE, funct3E, SrcAE, SrcBE, FlushE,
        output MDBusyE, MDDoneE, MDResultE
    );
endinterface

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative RV32M multiply/divide sequencer; MULDIV_EARLY_OUT_EN enables trivial-case early out
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic        clk,
    input  logic        reset,
    muldiv_seq_if.slave md
);

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY_OUT = 1'b1;
`else
    localparam bit EARLY_OUT = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_nxt;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   a_sh;
    logic [XLEN-1:0]   b_mag;
    logic [XLEN-1:0]   result_q;
    logic [2*XLEN-1:0] acc;
    logic [5:0]        cnt;
    logic              neg_res;
    logic              neg_rem;
    logic              div_zero;

    logic              accept;
    logic              last_iter;
    logic              a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]   a_abs, b_abs;
    logic              spec_hit;
    logic [XLEN-1:0]   spec_val;

    logic              bit_in;
    logic [XLEN:0]     div_t, div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] acc_mul, acc_div, acc_nxt, prod;
    logic [XLEN-1:0]   quo, rem, fin;

    assign accept    = (state == IDLE) && md.startE && !md.FlushE;
    assign last_iter = (state == RUN) && (cnt == 6'd31);

    // Operand decode at acceptance: MULHU/DIVU/REMU are fully unsigned, MULHSU only signs rs1.
    always_comb begin
        a_signed = !((md.funct3E == 3'b011) || (md.funct3E == 3'b101) || (md.funct3E == 3'b111));
        b_signed = a_signed && (md.funct3E != 3'b010);
        a_neg    = a_signed && md.SrcAE[XLEN-1];
        b_neg    = b_signed && md.SrcBE[XLEN-1];
        a_abs    = a_neg ? -md.SrcAE : md.SrcAE;
        b_abs    = b_neg ? -md.SrcBE : md.SrcBE;
    end

    // Results that are known without iterating: zero multiply, divide by zero, signed overflow.
    always_comb begin
        spec_hit = 1'b0;
        spec_val = '0;
        if (md.funct3E[2]) begin
            if (md.SrcBE == '0) begin
                spec_hit = 1'b1;
                spec_val = md.funct3E[1] ? md.SrcAE : {XLEN{1'b1}};
            end else if (!md.funct3E[0] &&
                         (md.SrcAE == {1'b1, {(XLEN-1){1'b0}}}) &&
                         (md.SrcBE == {XLEN{1'b1}})) begin
                spec_hit = 1'b1;
                spec_val = md.funct3E[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
            end
        end else if ((md.SrcAE == '0) || (md.SrcBE == '0)) begin
            spec_hit = 1'b1;
            spec_val = '0;
        end
    end

    // One iteration: rs1 magnitude is consumed MSB first by both the multiplier and the divider.
    always_comb begin
        bit_in   = a_sh[XLEN-1];
        acc_mul  = {acc[2*XLEN-2:0], 1'b0} + (bit_in ? {{XLEN{1'b0}}, b_mag} : '0);
        div_t    = {acc[2*XLEN-1:XLEN], bit_in};
        div_diff = div_t - {1'b0, b_mag};
        div_ge   = (div_t >= {1'b0, b_mag});
        acc_div  = {(div_ge ? div_diff[XLEN-1:0] : div_t[XLEN-1:0]), acc[XLEN-2:0], div_ge};
        acc_nxt  = op_q[2] ? acc_div : acc_mul;
    end

    always_comb begin
        prod = neg_res ? -acc_nxt : acc_nxt;
        quo  = acc_nxt[XLEN-1:0];
        rem  = acc_nxt[2*XLEN-1:XLEN];
        fin  = '0;
        case (op_q)
            3'b000:                 fin = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fin = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fin = (neg_res && !div_zero) ? -quo : quo;
            default:                fin = neg_rem ? -rem : rem;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (EARLY_OUT && spec_hit) ? DONE : RUN;
            RUN:  if (cnt == 6'd31) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (md.FlushE) state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q     <= '0;
            a_sh     <= '0;
            b_mag    <= '0;
            acc      <= '0;
            cnt      <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            result_q <= '0;
        end else begin
            if (accept) begin
                op_q     <= md.funct3E;
                a_sh     <= a_abs;
                b_mag    <= b_abs;
                neg_res  <= a_neg ^ b_neg;
                neg_rem  <= a_neg;
                div_zero <= (md.SrcBE == '0);
                acc      <= '0;
                cnt      <= '0;
                if (EARLY_OUT && spec_hit) result_q <= spec_val;
            end
            if (state == RUN) begin
                acc  <= acc_nxt;
                a_sh <= {a_sh[XLEN-2:0], 1'b0};
                cnt  <= cnt + 6'd1;
            end
            // A flush in the final iteration must leave the previous result visible.
            if (last_iter && !md.FlushE) result_q <= fin;
        end
    end

    assign md.MDBusyE   = (state == RUN) || accept;
    assign md.MDDoneE   = (state == DONE);
    assign md.MDResultE = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - self-checking bench for muldiv_seq with a randomized arithmetic reference model
module tb_muldiv_seq;

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] last_exp = '0;

    muldiv_seq_if #(.XLEN(32)) md();

    muldiv_seq #(.XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (md)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            3'b000: begin p = 64'(ua * ub); return p[31:0]; end
            3'b001: begin p = 64'(sa * sb); return p[63:32]; end
            3'b010: begin p = 64'(sa * longint'(ub)); return p[63:32]; end
            3'b011: begin p = 64'(ua * ub); return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFFFFFF;
                p = 64'(sa / sb); return p[31:0];
            end
            3'b101: begin
                if (b == 0) return 32'hFFFFFFFF;
                p = 64'(ua / ub); return p[31:0];
            end
            3'b110: begin
                if (b == 0) return a;
                p = 64'(sa % sb); return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = 64'(ua % ub); return p[31:0];
            end
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2]) return (b == 0) || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF);
        return (a == 0) || (b == 0);
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string name);
        int lat;
        lat = (EARLY && is_special(op, a, b)) ? 1 : 33;
        @(negedge clk);
        md.startE = 1'b1; md.FlushE = 1'b0;
        md.funct3E = op; md.SrcAE = a; md.SrcBE = b;
        #1;
        checks++;
        if (md.MDBusyE !== 1'b1) begin
            errors++; $display("FAIL %s busy_c0: got %b want 1", name, md.MDBusyE);
        end
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            checks++;
            if (md.MDBusyE !== logic'(k < lat)) begin
                errors++; $display("FAIL %s busy_c%0d: got %b want %b", name, k, md.MDBusyE, k < lat);
            end
            checks++;
            if (md.MDDoneE !== logic'(k == lat)) begin
                errors++; $display("FAIL %s done_c%0d: got %b want %b", name, k, md.MDDoneE, k == lat);
            end
            if (k == lat) begin
                checks++;
                if (md.MDResultE !== exp) begin
                    errors++; $display("FAIL %s result: got %h want %h (op %b a %h b %h)", name, md.MDResultE, exp, op, a, b);
                end
            end else begin
                md.SrcAE = $urandom; md.SrcBE = $urandom; md.funct3E = 3'($urandom);
            end
        end
        last_exp = exp;
        // startE stays high across the edge that leaves DONE, then the pipeline moves on.
        @(posedge clk); #1;
        md.startE = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        md.startE = 1'b0; md.FlushE = 1'b0; md.funct3E = '0; md.SrcAE = '0; md.SrcBE = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (md.MDBusyE !== 1'b0 || md.MDDoneE !== 1'b0 || md.MDResultE !== 32'h0) begin
            errors++; $display("FAIL reset_state: got busy %b done %b result %h want 0 0 0", md.MDBusyE, md.MDDoneE, md.MDResultE);
        end
        reset = 1'b0;
    endtask

    task automatic test_directed;
        run_op(3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, "mul");
        run_op(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, "mulh");
        run_op(3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, "mulhsu");
        run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu");
        run_op(3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, "div");
        run_op(3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, "rem");
        run_op(3'b101, 32'd100,      32'd7,        32'd14,       "divu");
        run_op(3'b111, 32'd100,      32'd7,        32'd2,        "remu");
        run_op(3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, "div_by0");
        run_op(3'b110, 32'd5,        32'd0,        32'd5,        "rem_by0");
        run_op(3'b101, 32'h12345678, 32'd0,        32'hFFFFFFFF, "divu_by0");
        run_op(3'b111, 32'h87654321, 32'd0,        32'h87654321, "remu_by0");
        run_op(3'b110, 32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, "rem_neg_by0");
        run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf");
        run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        "rem_ovf");
        run_op(3'b000, 32'd0,        32'hDEADBEEF, 32'd0,        "mul_zero");
    endtask

    task automatic test_random;
        logic [2:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom);
            a  = pick();
            b  = pick();
            run_op(op, a, b, model(op, a, b), "random");
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] a, b;
        a = $urandom; b = $urandom_range(1, 1000);
        run_op(3'b101, a, b, model(3'b101, a, b), "b2b_divu");
        run_op(3'b001, a, b, model(3'b001, a, b), "b2b_mulh");
        run_op(3'b110, a, b, model(3'b110, a, b), "b2b_rem");
    endtask

    task automatic test_hold;
        int bad;
        run_op(3'b000, 32'd3, 32'd5, 32'd15, "hold_mul");
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (md.MDDoneE !== 1'b0 || md.MDBusyE !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL hold_no_restart: got %0d busy/done cycles want 0", bad);
        end
    endtask

    task automatic test_flush;
        int dones;
        @(negedge clk);
        md.startE = 1'b1; md.FlushE = 1'b0; md.funct3E = 3'b100; md.SrcAE = 32'd1000; md.SrcBE = 32'd7;
        for (int k = 1; k <= 10; k++) @(negedge clk);
        checks++;
        if (md.MDBusyE !== 1'b1) begin
            errors++; $display("FAIL flush_busy_c10: got %b want 1", md.MDBusyE);
        end
        md.FlushE = 1'b1; md.startE = 1'b0;
        @(negedge clk);
        md.FlushE = 1'b0;
        checks++;
        if (md.MDBusyE !== 1'b0 || md.MDDoneE !== 1'b0) begin
            errors++; $display("FAIL flush_idle_c11: got busy %b done %b want 0 0", md.MDBusyE, md.MDDoneE);
        end
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (md.MDDoneE !== 1'b0) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++; $display("FAIL flush_no_done: got %0d done pulses want 0", dones);
        end
        checks++;
        if (md.MDResultE !== last_exp) begin
            errors++; $display("FAIL flush_result_kept: got %h want %h", md.MDResultE, last_exp);
        end
        run_op(3'b000, 32'd12, 32'd11, 32'd132, "after_flush_mul");

        @(negedge clk);
        md.startE = 1'b1; md.FlushE = 1'b1; md.funct3E = 3'b000; md.SrcAE = 32'd9; md.SrcBE = 32'd9;
        #1;
        checks++;
        if (md.MDBusyE !== 1'b0) begin
            errors++; $display("FAIL flush_wins_busy: got %b want 0", md.MDBusyE);
        end
        @(negedge clk);
        md.startE = 1'b0; md.FlushE = 1'b0;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (md.MDDoneE !== 1'b0 || md.MDBusyE !== 1'b0) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++; $display("FAIL flush_wins_no_accept: got %0d active cycles want 0", dones);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        md.startE = 1'b1; md.FlushE = 1'b0; md.funct3E = 3'b011; md.SrcAE = 32'hFFFF0000; md.SrcBE = 32'h0000FFFF;
        for (int k = 1; k <= 20; k++) @(negedge clk);
        reset = 1'b1; md.startE = 1'b0;
        #1;
        checks++;
        if (md.MDBusyE !== 1'b0 || md.MDDoneE !== 1'b0 || md.MDResultE !== 32'h0) begin
            errors++; $display("FAIL reset_mid: got busy %b done %b result %h want 0 0 0", md.MDBusyE, md.MDDoneE, md.MDResultE);
        end
        @(negedge clk);
        reset = 1'b0;
        last_exp = '0;
        run_op(3'b111, 32'd1001, 32'd10, 32'd1, "after_reset_remu");
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_back_to_back;
        test_hold;
        test_flush;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
